// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: state encoding,
// default response bytes and command-byte field positions.
package uart_cmd_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_READ_WAIT = 3'd4;
  localparam logic [2:0] S_SEND      = 3'd5;
  localparam logic [2:0] S_WAIT_TX   = 3'd6;

  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'h5A;

  localparam int WR_FLAG_BIT = 7;

  // Any set bit between the address field and the write flag makes the command illegal.
  function automatic logic cmd_illegal(input logic [7:0] cmd, input int addr_w);
    return (cmd[6:0] >> addr_w) != 7'd0;
  endfunction

endpackage

// File: rtl/uart_cmd.sv
// Byte-level command decoder: turns received UART bytes into single-register
// read/write bus cycles and returns one response byte per command.
module uart_cmd
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 50_000_000,
  parameter logic [7:0] ACK     = ACK_DEF,
  parameter logic [7:0] NAK     = NAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recieved,
  input  logic [7:0]        data_rx,
  input  logic              tx_busy,
  output logic              transmit,
  output logic [7:0]        data_tx,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              overrun
);

  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cmd_bad;
  logic             timeout_hit;
  logic             busy_state;

  assign cmd_bad     = cmd_illegal(data_rx, ADDR_W);
  assign timeout_hit = (cnt == CNT_LAST);
  assign busy_state  = (state != S_IDLE) && (state != S_GET_DATA);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (recieved) begin
          if (cmd_bad)                   state_nxt = S_SEND;
          else if (data_rx[WR_FLAG_BIT]) state_nxt = S_GET_DATA;
          else                           state_nxt = S_READ;
        end
      end
      S_GET_DATA: begin
        if (recieved)         state_nxt = S_WRITE;
        else if (timeout_hit) state_nxt = S_SEND;
      end
      S_WRITE:     state_nxt = S_SEND;
      S_READ:      state_nxt = S_READ_WAIT;
      S_READ_WAIT: state_nxt = S_SEND;
      S_SEND:      if (!tx_busy) state_nxt = S_WAIT_TX;
      // The UART raises tx_busy the cycle after transmit, so this state always lasts at least one cycle.
      S_WAIT_TX:   if (!tx_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_wr   = (state == S_WRITE);
    reg_rd   = (state == S_READ);
    transmit = (state == S_SEND) && !tx_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_tx   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      overrun   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (recieved) begin
            reg_addr <= data_rx[ADDR_W-1:0];
            cnt      <= '0;
            if (cmd_bad) data_tx <= NAK;
          end
        end
        S_GET_DATA: begin
          // A data byte landing on the final count still wins over the timeout.
          if (recieved)         reg_wdata <= data_rx;
          else if (timeout_hit) data_tx   <= NAK;
          else                  cnt       <= cnt + 1'b1;
        end
        S_WRITE:     data_tx <= ACK;
        S_READ_WAIT: data_tx <= reg_rdata;
        default: ;
      endcase
      if (recieved && busy_state) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd.sv
// Directed bench for uart_cmd: table of single-command vectors plus
// hand-written timeout, backpressure/overrun and reset-abort sequences.
module tb_uart_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       recieved;
  logic [7:0] data_rx;
  logic       tx_busy;
  logic       transmit;
  logic [7:0] data_tx;
  logic       reg_wr;
  logic       reg_rd;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       overrun;

  uart_cmd #(.ADDR_W(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .recieved(recieved), .data_rx(data_rx),
    .tx_busy(tx_busy), .transmit(transmit), .data_tx(data_tx),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // UART TX model: busy for 4 cycles starting the cycle after transmit.
  int   cyc = 0;
  int   busy_cnt = 0;
  logic force_busy;
  logic rd_d = 1'b0;
  logic [7:0] rdata_val;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_d <= reg_rd;
    if (transmit)          busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy   = force_busy | (busy_cnt != 0);
  // Register file model: read data only valid the cycle after reg_rd.
  assign reg_rdata = rd_d ? rdata_val : 8'h00;

  int         wr_tot = 0, rd_tot = 0, tx_tot = 0, prot_err = 0;
  int         tx_cyc = 0;
  logic [7:0] tx_byte = 8'h00, wr_data = 8'h00;
  logic [3:0] wr_addr = 4'h0, rd_addr = 4'h0;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_tot  <= wr_tot + 1;
      wr_addr <= reg_addr;
      wr_data <= reg_wdata;
    end
    if (reg_rd) begin
      rd_tot  <= rd_tot + 1;
      rd_addr <= reg_addr;
    end
    if (transmit) begin
      tx_tot  <= tx_tot + 1;
      tx_byte <= data_tx;
      tx_cyc  <= cyc;
    end
    if ((reg_wr && reg_rd) || (transmit && tx_busy)) prot_err <= prot_err + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int s);
    @(negedge clk);
    recieved = 1'b1;
    data_rx  = b;
    s        = cyc;
    @(negedge clk);
    recieved = 1'b0;
    data_rx  = 8'h00;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       has_data;
    logic [7:0] data;
    logic [7:0] rdata;
    int         exp_wr;
    int         exp_rd;
    logic [3:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_tx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input string nm);
    int b_wr, b_rd, b_tx, s;
    b_wr = wr_tot; b_rd = rd_tot; b_tx = tx_tot;
    rdata_val = v.rdata;
    send(v.cmd, s);
    if (v.has_data) send(v.data, s);
    for (int i = 0; i < 40 && tx_tot == b_tx; i++) @(posedge clk);
    repeat (12) @(negedge clk);
    check({nm, " wr_count"}, wr_tot - b_wr, v.exp_wr);
    check({nm, " rd_count"}, rd_tot - b_rd, v.exp_rd);
    check({nm, " tx_count"}, tx_tot - b_tx, 1);
    check({nm, " tx_byte"}, tx_byte, v.exp_tx);
    check({nm, " latency"}, tx_cyc - s, v.exp_lat);
    if (v.exp_wr != 0) begin
      check({nm, " wr_addr"}, wr_addr, v.exp_addr);
      check({nm, " wr_data"}, wr_data, v.exp_wdata);
    end
    if (v.exp_rd != 0) check({nm, " rd_addr"}, rd_addr, v.exp_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, b_tx, b_wr, b_rd;
    //           cmd    dat   data   rdata  wr rd addr  wdata  tx     lat
    vecs[0] = '{8'h83, 1'b1, 8'h3C, 8'h00, 1, 0, 4'h3, 8'h3C, 8'hA5, 2};
    vecs[1] = '{8'h05, 1'b0, 8'h00, 8'hC7, 0, 1, 4'h5, 8'h00, 8'hC7, 3};
    vecs[2] = '{8'h45, 1'b0, 8'h00, 8'h00, 0, 0, 4'h0, 8'h00, 8'h5A, 1};
    vecs[3] = '{8'h8F, 1'b1, 8'hFF, 8'h00, 1, 0, 4'hF, 8'hFF, 8'hA5, 2};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 8'h81, 0, 1, 4'h0, 8'h00, 8'h81, 3};
    vecs[5] = '{8'h90, 1'b0, 8'h00, 8'h00, 0, 0, 4'h0, 8'h00, 8'h5A, 1};
    vecs[6] = '{8'h0A, 1'b0, 8'h00, 8'h00, 0, 1, 4'hA, 8'h00, 8'h00, 3};
    vecs[7] = '{8'hC1, 1'b0, 8'h00, 8'h00, 0, 0, 4'h0, 8'h00, 8'h5A, 1};
    vecs[8] = '{8'h01, 1'b0, 8'h00, 8'h3E, 0, 1, 4'h1, 8'h00, 8'h3E, 3};
    vecs[9] = '{8'h02, 1'b0, 8'h00, 8'h9D, 0, 1, 4'h2, 8'h00, 8'h9D, 3};

    rst = 1'b1; recieved = 1'b0; data_rx = 8'h00; force_busy = 1'b0; rdata_val = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset transmit",  transmit,  0);
    check("reset data_tx",   data_tx,   0);
    check("reset reg_wr",    reg_wr,    0);
    check("reset reg_rd",    reg_rd,    0);
    check("reset reg_addr",  reg_addr,  0);
    check("reset reg_wdata", reg_wdata, 0);
    check("reset overrun",   overrun,   0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("hold reg_wdata", reg_wdata, 8'hFF);

    // Timeout: write command with no data byte.
    b_tx = tx_tot; b_wr = wr_tot;
    send(8'h81, s);
    for (int i = 0; i < 150 && tx_tot == b_tx; i++) @(posedge clk);
    repeat (12) @(negedge clk);
    check("timeout tx_count", tx_tot - b_tx, 1);
    check("timeout tx_byte",  tx_byte, 8'h5A);
    check("timeout latency",  tx_cyc - s, 101);
    check("timeout wr_count", wr_tot - b_wr, 0);
    run_vec(vecs[8], "after_timeout");

    // Backpressure and overrun.
    check("overrun before", overrun, 0);
    b_tx = tx_tot; b_rd = rd_tot; b_wr = wr_tot;
    @(negedge clk);
    force_busy = 1'b1;
    send(8'h45, s);
    repeat (2) @(negedge clk);
    send(8'h12, s);
    repeat (3) @(negedge clk);
    check("backpressure tx_held", tx_tot - b_tx, 0);
    check("overrun set",          overrun, 1);
    force_busy = 1'b0;
    repeat (12) @(negedge clk);
    check("backpressure tx_count", tx_tot - b_tx, 1);
    check("backpressure tx_byte",  tx_byte, 8'h5A);
    check("dropped byte rd_count", rd_tot - b_rd, 0);
    check("dropped byte wr_count", wr_tot - b_wr, 0);
    check("overrun sticky",        overrun, 1);

    // Reset in the middle of a write.
    b_tx = tx_tot; b_wr = wr_tot;
    send(8'h84, s);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst transmit",  transmit,  0);
    check("midrst data_tx",   data_tx,   0);
    check("midrst reg_wr",    reg_wr,    0);
    check("midrst reg_addr",  reg_addr,  0);
    check("midrst reg_wdata", reg_wdata, 0);
    check("midrst overrun",   overrun,   0);
    repeat (120) @(negedge clk);
    check("midrst tx_count", tx_tot - b_tx, 0);
    check("midrst wr_count", wr_tot - b_wr, 0);
    run_vec(vecs[9], "after_reset");

    check("protocol violations", prot_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
